lstm_bptt_buffer: RTL and testbench

//  Captures the per-timestep LSTM forward state (a, i, f, o, c, h) produced by the lstm

---
 rtl/lstm_bptt_buffer_pkg.sv | 28 ++
 rtl/lstm_state_mem.sv | 36 +++
 rtl/lstm_bptt_buffer.sv | 146 ++++++++++++++
 tb/tb_lstm_bptt_buffer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_bptt_buffer_pkg.sv
// Shared constants for the LSTM BPTT replay buffer.
// Gate-record field order, widths and the pop/push op decode.
package lstm_bptt_buffer_pkg;

  localparam int WIDTH_DEF    = 32;
  localparam int NUM_GATES_ST = 6;

  // Field slots inside one stored record {a,i,f,o,c,h}, in
  // units of NUM_LSTM*WIDTH, counted from the LSB.
  localparam int OFF_H = 0;
  localparam int OFF_C = 1;
  localparam int OFF_O = 2;
  localparam int OFF_F = 3;
  localparam int OFF_I = 4;
  localparam int OFF_A = 5;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_CLR
  } op_e;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/lstm_state_mem.sv
// Register file for LSTM timestep records: one sync write port,
// async read of the top record and of the c field one below it.
// Ports: i_we/i_waddr/i_wdata write; i_raddr0 -> o_rdata0 (record);
//        i_raddr1 -> o_rdata1_c (c field only).
module lstm_state_mem
  import lstm_bptt_buffer_pkg::*;
#(
  parameter int LW     = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [ADDR_W-1:0]          i_waddr,
  input  logic [NUM_GATES_ST*LW-1:0] i_wdata,
  input  logic [ADDR_W-1:0]          i_raddr0,
  output logic [NUM_GATES_ST*LW-1:0] o_rdata0,
  input  logic [ADDR_W-1:0]          i_raddr1,
  output logic [LW-1:0]              o_rdata1_c
);

  localparam int RW = NUM_GATES_ST * LW;

  logic [RW-1:0] r_mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata0   = r_mem[i_raddr0];
  assign o_rdata1_c = r_mem[i_raddr1][OFF_C*LW +: LW];

endmodule

// File: rtl/lstm_bptt_buffer.sv
// LIFO replay of per-timestep LSTM state for BPTT, with c(t-1).
// Ports: clk, rst (async low), i_clr/i_wr_en/i_rd_en, i_a..i_h in;
//        o_a..o_h, o_c_prev, o_valid, o_count, o_full, o_empty, o_err.
module lstm_bptt_buffer
  import lstm_bptt_buffer_pkg::*;
#(
  parameter int WIDTH          = WIDTH_DEF,
  parameter int NUM_LSTM       = 1,
  parameter int NUM_ITERATIONS = 8,
  parameter int ADDR_W         = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clr,
  input  logic                      i_wr_en,
  input  logic [NUM_LSTM*WIDTH-1:0] i_a,
  input  logic [NUM_LSTM*WIDTH-1:0] i_i,
  input  logic [NUM_LSTM*WIDTH-1:0] i_f,
  input  logic [NUM_LSTM*WIDTH-1:0] i_o,
  input  logic [NUM_LSTM*WIDTH-1:0] i_c,
  input  logic [NUM_LSTM*WIDTH-1:0] i_h,
  input  logic                      i_rd_en,
  output logic [NUM_LSTM*WIDTH-1:0] o_a,
  output logic [NUM_LSTM*WIDTH-1:0] o_i,
  output logic [NUM_LSTM*WIDTH-1:0] o_f,
  output logic [NUM_LSTM*WIDTH-1:0] o_o,
  output logic [NUM_LSTM*WIDTH-1:0] o_c,
  output logic [NUM_LSTM*WIDTH-1:0] o_h,
  output logic [NUM_LSTM*WIDTH-1:0] o_c_prev,
  output logic                      o_valid,
  output logic [ADDR_W:0]           o_count,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_err
);

  localparam int LW = NUM_LSTM * WIDTH;
  localparam int RW = NUM_GATES_ST * LW;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(NUM_ITERATIONS);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  if (ADDR_W != addr_w(NUM_ITERATIONS)) begin : g_addr_chk
    $error("ADDR_W must equal clog2(NUM_ITERATIONS)");
  end

  logic [ADDR_W:0]   r_count;
  logic [RW-1:0]     r_rec;
  logic [LW-1:0]     r_c_prev;
  logic              r_valid;
  logic              r_err;

  logic              w_full;
  logic              w_empty;
  logic              w_err_evt;
  logic              w_we;
  op_e               w_op;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_top_addr;
  logic [ADDR_W-1:0] w_prev_addr;
  logic [RW-1:0]     w_wdata;
  logic [RW-1:0]     w_top;
  logic [LW-1:0]     w_prev_c;

  assign w_full  = (r_count == DEPTH);
  assign w_empty = (r_count == '0);

  // Narrow pointer math: at count==DEPTH the low bits are 0 and
  // the subtraction wraps to the correct top/top-1 slots.
  assign w_waddr     = r_count[ADDR_W-1:0];
  assign w_top_addr  = w_waddr - ADDR_W'(1);
  assign w_prev_addr = w_waddr - ADDR_W'(2);

  assign w_wdata = {i_a, i_i, i_f, i_o, i_c, i_h};

  always_comb begin
    w_op = OP_IDLE;
    unique case (1'b1)
      i_clr:                          w_op = OP_CLR;
      !i_clr && i_rd_en:              w_op = OP_POP;
      !i_clr && !i_rd_en && i_wr_en:  w_op = OP_PUSH;
      default:                        w_op = OP_IDLE;
    endcase
  end

  // A push colliding with a pop is dropped but still flagged.
  assign w_err_evt = (i_wr_en && (i_rd_en || w_full)) ||
                     (i_rd_en && w_empty);

  assign w_we = (w_op == OP_PUSH) && !w_full;

  lstm_state_mem #(
    .LW     (LW),
    .DEPTH  (NUM_ITERATIONS),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk        (clk),
    .i_we       (w_we),
    .i_waddr    (w_waddr),
    .i_wdata    (w_wdata),
    .i_raddr0   (w_top_addr),
    .o_rdata0   (w_top),
    .i_raddr1   (w_prev_addr),
    .o_rdata1_c (w_prev_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= '0;
      r_rec    <= '0;
      r_c_prev <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_op == OP_CLR) begin
        r_count <= '0;
        r_err   <= 1'b0;
      end else begin
        r_err <= r_err | w_err_evt;
        if (w_op == OP_POP && !w_empty) begin
          r_count  <= r_count - ONE;
          r_rec    <= w_top;
          r_c_prev <= (r_count == ONE) ? '0 : w_prev_c;
          r_valid  <= 1'b1;
        end
        if (w_we) begin
          r_count <= r_count + ONE;
        end
      end
    end
  end

  assign o_a      = r_rec[OFF_A*LW +: LW];
  assign o_i      = r_rec[OFF_I*LW +: LW];
  assign o_f      = r_rec[OFF_F*LW +: LW];
  assign o_o      = r_rec[OFF_O*LW +: LW];
  assign o_c      = r_rec[OFF_C*LW +: LW];
  assign o_h      = r_rec[OFF_H*LW +: LW];
  assign o_c_prev = r_c_prev;
  assign o_valid  = r_valid;
  assign o_count  = r_count;
  assign o_full   = w_full;
  assign o_empty  = w_empty;
  assign o_err    = r_err;

endmodule

// File: tb/tb_lstm_bptt_buffer.sv
// Bench for lstm_bptt_buffer: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_lstm_bptt_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_clr, i_wr_en, i_rd_en;
  logic [31:0] i_a, i_i, i_f, i_o, i_c, i_h;
  logic [31:0] o_a, o_i, o_f, o_o, o_c, o_h, o_c_prev;
  logic        o_valid, o_full, o_empty, o_err;
  logic [3:0]  o_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lstm_bptt_buffer dut (
    .clk(clk), .rst(rst), .i_clr(i_clr), .i_wr_en(i_wr_en),
    .i_a(i_a), .i_i(i_i), .i_f(i_f), .i_o(i_o),
    .i_c(i_c), .i_h(i_h), .i_rd_en(i_rd_en),
    .o_a(o_a), .o_i(o_i), .o_f(o_f), .o_o(o_o),
    .o_c(o_c), .o_h(o_h), .o_c_prev(o_c_prev),
    .o_valid(o_valid), .o_count(o_count), .o_full(o_full),
    .o_empty(o_empty), .o_err(o_err)
  );

  typedef struct {
    logic [31:0] a, i, f, o, c, h;
  } rec_t;

  typedef struct {
    bit          wr, rd;
    logic [31:0] h, c;
    int          cnt;
    bit          vld, err;
    logic [31:0] eh, ecp;
  } vec_t;

  rec_t        mq[$];
  rec_t        m_out;
  logic [31:0] m_cp;
  bit          m_v, m_e;
  vec_t        tv[17];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic rec_t mkrec(input logic [31:0] h, input logic [31:0] c);
    rec_t r;
    r.h = h;
    r.c = c;
    r.a = h ^ 32'h8000_0001;
    r.i = ~h;
    r.f = {h[15:0], h[31:16]};
    r.o = h + 32'h1234_0000;
    return r;
  endfunction

  task automatic drive(input bit wr, input bit rd, input bit cl,
                       input logic [31:0] h, input logic [31:0] c);
    rec_t r;
    r = mkrec(h, c);
    i_wr_en = wr; i_rd_en = rd; i_clr = cl;
    i_a = r.a; i_i = r.i; i_f = r.f; i_o = r.o; i_c = r.c; i_h = r.h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] c);
    drive(1, 0, 0, h, c);
    tick();
  endtask

  // Reference: a plain LIFO queue plus the observable rules.
  task automatic model_step(input bit wr, input bit rd, input bit cl,
                            input rec_t r);
    if (cl) begin
      mq.delete();
      m_v = 0;
      m_e = 0;
    end else begin
      m_v = 0;
      if (rd) begin
        if (mq.size() == 0) begin
          m_e = 1;
        end else begin
          m_out = mq.pop_back();
          m_cp  = (mq.size() > 0) ? mq[$].c : 32'd0;
          m_v   = 1;
        end
        if (wr) m_e = 1;
      end else if (wr) begin
        if (mq.size() == 8) m_e = 1;
        else mq.push_back(r);
      end
    end
  endtask

  task automatic check_all();
    chk("rnd_count", 64'(o_count), 64'(mq.size()));
    chk("rnd_full", 64'(o_full), 64'(mq.size() == 8));
    chk("rnd_empty", 64'(o_empty), 64'(mq.size() == 0));
    chk("rnd_valid", 64'(o_valid), 64'(m_v));
    chk("rnd_err", 64'(o_err), 64'(m_e));
    chk("rnd_a", 64'(o_a), 64'(m_out.a));
    chk("rnd_i", 64'(o_i), 64'(m_out.i));
    chk("rnd_f", 64'(o_f), 64'(m_out.f));
    chk("rnd_o", 64'(o_o), 64'(m_out.o));
    chk("rnd_c", 64'(o_c), 64'(m_out.c));
    chk("rnd_h", 64'(o_h), 64'(m_out.h));
    chk("rnd_cprev", 64'(o_c_prev), 64'(m_cp));
  endtask

  initial begin
    // Table: 8 pushes h=t+1, c=100+t, then 8 pops, then idle.
    for (int t = 0; t < 8; t++) begin
      tv[t] = '{wr: 1, rd: 0, h: t + 1, c: 100 + t, cnt: t + 1,
                vld: 0, err: 0, eh: 0, ecp: 0};
    end
    for (int k = 0; k < 8; k++) begin
      int t;
      t = 7 - k;
      tv[8 + k] = '{wr: 0, rd: 1, h: 0, c: 0, cnt: t, vld: 1, err: 0,
                    eh: t + 1, ecp: (t == 0) ? 0 : 100 + t - 1};
    end
    tv[16] = '{wr: 0, rd: 0, h: 0, c: 0, cnt: 0, vld: 0, err: 0,
               eh: 1, ecp: 0};

    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    tick();

    chk("rst_count", 64'(o_count), 0);
    chk("rst_empty", 64'(o_empty), 1);
    chk("rst_valid", 64'(o_valid), 0);
    chk("rst_err", 64'(o_err), 0);
    chk("rst_h", 64'(o_h), 0);

    foreach (tv[n]) begin
      drive(tv[n].wr, tv[n].rd, 0, tv[n].h, tv[n].c);
      tick();
      chk($sformatf("tv%0d_count", n), 64'(o_count), 64'(tv[n].cnt));
      chk($sformatf("tv%0d_full", n), 64'(o_full), 64'(tv[n].cnt == 8));
      chk($sformatf("tv%0d_empty", n), 64'(o_empty), 64'(tv[n].cnt == 0));
      chk($sformatf("tv%0d_valid", n), 64'(o_valid), 64'(tv[n].vld));
      chk($sformatf("tv%0d_err", n), 64'(o_err), 64'(tv[n].err));
      chk($sformatf("tv%0d_h", n), 64'(o_h), 64'(tv[n].eh));
      chk($sformatf("tv%0d_cprev", n), 64'(o_c_prev), 64'(tv[n].ecp));
    end

    // Overflow: 9th push dropped, next pop returns entry 8.
    for (int t = 0; t < 8; t++) push(t + 1, 200 + t);
    push(99, 299);
    chk("ovf_count", 64'(o_count), 8);
    chk("ovf_err", 64'(o_err), 1);
    chk("ovf_full", 64'(o_full), 1);
    drive(0, 1, 0, 0, 0);
    tick();
    chk("ovf_pop_h", 64'(o_h), 8);
    chk("ovf_pop_valid", 64'(o_valid), 1);
    chk("ovf_pop_cprev", 64'(o_c_prev), 206);
    chk("ovf_pop_count", 64'(o_count), 7);

    // Collision at count 3: pop wins, push dropped.
    drive(0, 0, 1, 0, 0);
    tick();
    chk("clr_count", 64'(o_count), 0);
    chk("clr_err", 64'(o_err), 0);
    push(11, 21);
    push(12, 22);
    push(13, 23);
    drive(1, 1, 0, 77, 77);
    tick();
    chk("col_h", 64'(o_h), 13);
    chk("col_cprev", 64'(o_c_prev), 22);
    chk("col_count", 64'(o_count), 2);
    chk("col_err", 64'(o_err), 1);
    chk("col_valid", 64'(o_valid), 1);

    // Clear with write high at count 5, then pop on empty.
    drive(0, 0, 1, 0, 0);
    tick();
    for (int t = 0; t < 5; t++) push(30 + t, 40 + t);
    chk("pre_clr_count", 64'(o_count), 5);
    drive(1, 0, 1, 55, 55);
    tick();
    chk("clrwr_count", 64'(o_count), 0);
    chk("clrwr_err", 64'(o_err), 0);
    chk("clrwr_valid", 64'(o_valid), 0);
    chk("clrwr_hold_h", 64'(o_h), 13);
    drive(0, 1, 0, 0, 0);
    tick();
    chk("udf_valid", 64'(o_valid), 0);
    chk("udf_err", 64'(o_err), 1);
    chk("udf_count", 64'(o_count), 0);
    chk("udf_hold_h", 64'(o_h), 13);

    // Async reset mid-cycle right after a pop.
    drive(0, 0, 1, 0, 0);
    tick();
    push(1, 5);
    push(2, 6);
    push(3, 7);
    drive(0, 1, 0, 0, 0);
    tick();
    chk("pre_rst_valid", 64'(o_valid), 1);
    chk("pre_rst_h", 64'(o_h), 3);
    drive(0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_count", 64'(o_count), 0);
    chk("arst_empty", 64'(o_empty), 1);
    chk("arst_valid", 64'(o_valid), 0);
    chk("arst_h", 64'(o_h), 0);
    chk("arst_cprev", 64'(o_c_prev), 0);
    #2 rst = 1'b1;
    tick();

    // Randomized traffic against the queue model.
    mq.delete();
    m_out = mkrec(0, 0);
    m_out = '{a: 0, i: 0, f: 0, o: 0, c: 0, h: 0};
    m_cp  = 0;
    m_v   = 0;
    m_e   = 0;
    for (int n = 0; n < 400; n++) begin
      bit          wr, rd, cl;
      logic [31:0] h, c;
      cl = ($urandom % 100) < 3;
      wr = ($urandom % 100) < 55;
      rd = ($urandom % 100) < 40;
      h  = $urandom;
      c  = $urandom;
      drive(wr, rd, cl, h, c);
      model_step(wr, rd, cl, mkrec(h, c));
      tick();
      check_all();
    end

    drive(0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
